usr_exec_unit: RTL and testbench
================================

USR_EXEC_UNIT -- requirements
Module: usr_exec_unit

Interface
REQ-001 Parameter: WIDTH, 4, register width in bits; fixed at 4 for this release.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: cmd_valid  input  1  command offered by main controller.
REQ-005 Port: cmd_ready  output  1  unit can accept a command.
REQ-006 Port: cmd_op  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port: cmd_cnt  input  2  shift amount minus one (00 = 1 shift, 11 = 4 shifts).
REQ-008 Port: cmd_rot  input  1  1 = rotate (fill from opposite end), 0 = serial fill.
REQ-009 Port: load_data  input  WIDTH  parallel load value.
REQ-010 Port: ser_in_r  input  1  MSB fill bit for shift right, sampled each shift cycle.
REQ-011 Port: ser_in_l  input  1  LSB fill bit for shift left, sampled each shift cycle.
REQ-012 Port: busy  output  1  command in progress (EXEC or DONE).
REQ-013 Port: done  output  1  one-cycle completion pulse.
REQ-014 Port: Q_out  output  WIDTH  register contents.

Function
REQ-015 States: IDLE, EXEC, DONE; registered state, one-hot or binary at implementer's choice.
REQ-016 cmd_ready = 1 only in IDLE; busy = not cmd_ready; done = 1 only in DONE.
REQ-017 Accept = cmd_valid & cmd_ready at a rising edge; cmd_op, cmd_cnt, cmd_rot, load_data latched at that edge; IDLE -> EXEC.
REQ-018 cmd_valid while not ready is ignored; no queuing, no error.
REQ-019 Shift right: Q <= {fill, Q[3:1]}; fill = Q[0] if rot else ser_in_r.
REQ-020 Shift left: Q <= {Q[2:0], fill}; fill = Q[3] if rot else ser_in_l.
REQ-021 Shift ops: EXEC lasts cmd_cnt+1 cycles, one shift per edge; internal 2-bit down-counter tracks remaining shifts.
REQ-022 Load: EXEC lasts 1 cycle; Q <= latched load_data at the edge leaving EXEC.
REQ-023 Hold: EXEC lasts 1 cycle; Q unchanged.
REQ-024 Final EXEC edge -> DONE; DONE lasts exactly 1 cycle -> IDLE.
REQ-025 Latency accept edge to done high: cmd_cnt+2 cycles (shift), 2 cycles (load/hold); back-to-back accept possible on the edge after DONE.
REQ-026 Rotate by 4 (cmd_cnt=11, rot=1) returns Q to its pre-command value.
REQ-027 Serial fill inputs changing mid-command take effect at the next shift edge.

Reset
REQ-028 reset low: state IDLE, Q_out = 0000, counter = 0, done = 0, busy = 0, cmd_ready = 1, independent of clk.
REQ-029 reset asserted mid-command aborts it; no done pulse is produced for the aborted command.
REQ-030 First accept possible at the first rising edge with reset high.

Structure
REQ-031 Shared package usr_pkg holds: WIDTH default, op encodings (OP_HOLD, OP_SHR, OP_SHL, OP_LOAD), state encoding; the main controller uses the same package.
REQ-032 One sub-module usr_shift_core: combinational next-Q mux from op, rot, fill bits, load value and current Q.
REQ-033 Top holds FSM, shift counter, command latch, Q register.

Verification
REQ-034 Reset low then high, no command -> Q_out=0000, cmd_ready=1, busy=0, done=0.
REQ-035 Load 1011 -> done high on accept+2 cycles, Q_out=1011; then SHR cnt=01 rot=0 ser_in_r=1 -> Q_out 1101 then 1110, done at accept+3.
REQ-036 Q=1011, SHL cnt=11 rot=1 -> Q_out 0111,1110,1101,1011; done at accept+5.
REQ-037 cmd_valid held high with differing commands during EXEC -> ignored; only command latched at accept executes.
REQ-038 reset pulsed low during 3rd shift of 4-shift command -> Q_out=0000 immediately, no done, cmd_ready=1 after release.
REQ-039 Hold accepted with Q=0110 -> Q unchanged, done pulse exactly one cycle at accept+2, next command accepted the following edge.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the user shift-register execution unit and its controller.
// Holds the register width, command opcodes and FSM state encoding.
package usr_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LOAD = 2'b11
    } usr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } usr_state_e;

    function automatic logic is_shift(input usr_op_e op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/usr_shift_core.sv
// Combinational next-value mux for the shift register: hold, shift right/left
// (rotate or serial fill) and parallel load.
module usr_shift_core
    import usr_pkg::*;
#(
    parameter int WIDTH = usr_pkg::WIDTH
) (
    input  usr_op_e          op,
    input  logic             rot,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            OP_SHR:  q_next = {(rot ? q[0] : ser_in_r), q[WIDTH-1:1]};
            OP_SHL:  q_next = {q[WIDTH-2:0], (rot ? q[WIDTH-1] : ser_in_l)};
            OP_LOAD: q_next = load_val;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/usr_exec_unit.sv
// Shift-register execution unit: accepts one command at a time, runs it over
// one or more EXEC cycles, then pulses done for a single cycle.
module usr_exec_unit
    import usr_pkg::*;
#(
    parameter int WIDTH = usr_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_cnt,
    input  logic             cmd_rot,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q_out,
    output usr_state_e       dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_valid while cmd_ready is low is dropped.
    usr_state_e       state;
    usr_op_e          op_q;
    logic             rot_q;
    logic [WIDTH-1:0] load_q;
    logic [1:0]       cnt;
    logic [WIDTH-1:0] q_next;

    assign dbg_state = state;

    usr_shift_core #(.WIDTH(WIDTH)) u_core (
        .op       (op_q),
        .rot      (rot_q),
        .ser_in_r (ser_in_r),
        .ser_in_l (ser_in_l),
        .load_val (load_q),
        .q        (Q_out),
        .q_next   (q_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_HOLD;
            rot_q     <= 1'b0;
            load_q    <= '0;
            cnt       <= 2'd0;
            Q_out     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= usr_op_e'(cmd_op);
                        rot_q     <= cmd_rot;
                        load_q    <= load_data;
                        // Hold and load always finish after a single EXEC cycle.
                        cnt       <= is_shift(usr_op_e'(cmd_op)) ? cmd_cnt : 2'd0;
                        state     <= ST_EXEC;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    Q_out <= q_next;
                    if (cnt == 2'd0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usr_exec_unit.sv
// Directed testbench for usr_exec_unit: one task per scenario with
// hand-computed expected register values and handshake timing.
module tb_usr_exec_unit;
    import usr_pkg::*;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_cnt;
    logic       cmd_rot;
    logic [3:0] load_data;
    logic       ser_in_r;
    logic       ser_in_l;
    logic       busy;
    logic       done;
    logic [3:0] Q_out;
    usr_state_e dbg_state;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    usr_exec_unit #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_rot   (cmd_rot),
        .load_data (load_data),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .busy      (busy),
        .done      (done),
        .Q_out     (Q_out),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for cmd_ready, presents the command and returns 1ns
    // after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [1:0] cnt, input logic rot,
                         input logic [3:0] data, input bit keep_valid);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: cmd_ready=%b want 1 after %0d cycles", cmd_ready, n);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_rot   = rot;
        load_data = data;
        step();
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if (Q_out !== 4'b0000) begin errors++; $display("FAIL reset_q: got %b want 0000", Q_out); end
        checks++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            errors++; $display("FAIL reset_flags: ready/busy/done=%b want 100", {cmd_ready, busy, done});
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({Q_out, cmd_ready, busy, done} !== 7'b0000_100) begin
            errors++; $display("FAIL idle_after_reset: q/ready/busy/done=%b want 0000100", {Q_out, cmd_ready, busy, done});
        end
    endtask

    task automatic test_first_accept();
        reset = 1'b0;
        #2;
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_cnt   = 2'b00;
        cmd_rot   = 1'b0;
        load_data = 4'b1011;
        @(negedge clk);
        reset = 1'b1;
        step();
        cmd_valid = 1'b0;
        checks++;
        if ({busy, cmd_ready} !== 2'b10) begin
            errors++; $display("FAIL first_accept: busy/ready=%b want 10", {busy, cmd_ready});
        end
        step();
        checks++;
        if ({done, Q_out} !== 5'b1_1011) begin
            errors++; $display("FAIL first_accept_done: done/q=%b want 11011", {done, Q_out});
        end
        step();
    endtask

    task automatic test_load();
        issue(OP_LOAD, 2'b00, 1'b0, 4'b1011, 1'b0);
        checks++;
        if ({busy, cmd_ready, done} !== 3'b100) begin
            errors++; $display("FAIL load_exec: busy/ready/done=%b want 100", {busy, cmd_ready, done});
        end
        step();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL load_done: got %b want 1", done); end
        checks++;
        if (Q_out !== 4'b1011) begin errors++; $display("FAIL load_q: got %b want 1011", Q_out); end
        step();
        checks++;
        if ({done, cmd_ready, busy} !== 3'b010) begin
            errors++; $display("FAIL load_idle: done/ready/busy=%b want 010", {done, cmd_ready, busy});
        end
    endtask

    task automatic test_shr();
        ser_in_r = 1'b1;
        issue(OP_SHR, 2'b01, 1'b0, 4'b0000, 1'b0);
        checks++;
        if ({done, Q_out} !== 5'b0_1011) begin errors++; $display("FAIL shr_c0: done/q=%b want 01011", {done, Q_out}); end
        step();
        checks++;
        if ({done, Q_out} !== 5'b0_1101) begin errors++; $display("FAIL shr_c1: done/q=%b want 01101", {done, Q_out}); end
        step();
        checks++;
        if ({done, Q_out} !== 5'b1_1110) begin errors++; $display("FAIL shr_c2: done/q=%b want 11110", {done, Q_out}); end
        step();
        checks++;
        if ({done, cmd_ready} !== 2'b01) begin errors++; $display("FAIL shr_end: done/ready=%b want 01", {done, cmd_ready}); end
    endtask

    task automatic test_serial_change();
        ser_in_r = 1'b0;
        issue(OP_SHR, 2'b01, 1'b0, 4'b0000, 1'b0);
        step();
        checks++;
        if (Q_out !== 4'b0111) begin errors++; $display("FAIL serial_c1: got %b want 0111", Q_out); end
        ser_in_r = 1'b1;
        step();
        checks++;
        if ({done, Q_out} !== 5'b1_1011) begin errors++; $display("FAIL serial_c2: done/q=%b want 11011", {done, Q_out}); end
        step();
    endtask

    task automatic test_rotate();
        logic [3:0] e;
        exp_q = {};
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b1101);
        exp_q.push_back(4'b1011);
        issue(OP_SHL, 2'b11, 1'b1, 4'b0000, 1'b0);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rot_c0_done: got %b want 0", done); end
        for (int i = 0; i < 4; i++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if (Q_out !== e) begin errors++; $display("FAIL rot_q[%0d]: got %b want %b", i, Q_out, e); end
            checks++;
            if (done !== (i == 3)) begin errors++; $display("FAIL rot_done[%0d]: got %b want %b", i, done, (i == 3)); end
        end
        step();
        checks++;
        if ({done, cmd_ready} !== 2'b01) begin errors++; $display("FAIL rot_end: done/ready=%b want 01", {done, cmd_ready}); end
    endtask

    task automatic test_ignore();
        issue(OP_SHR, 2'b10, 1'b1, 4'b0000, 1'b1);
        cmd_op = OP_LOAD; cmd_cnt = 2'b11; cmd_rot = 1'b0; load_data = 4'b0000;
        step();
        checks++;
        if ({busy, Q_out} !== 5'b1_1101) begin errors++; $display("FAIL ign_c1: busy/q=%b want 11101", {busy, Q_out}); end
        cmd_op = OP_SHL;
        step();
        checks++;
        if ({busy, Q_out} !== 5'b1_1110) begin errors++; $display("FAIL ign_c2: busy/q=%b want 11110", {busy, Q_out}); end
        cmd_op = OP_HOLD;
        step();
        checks++;
        if ({done, Q_out} !== 5'b1_0111) begin errors++; $display("FAIL ign_c3: done/q=%b want 10111", {done, Q_out}); end
        cmd_valid = 1'b0;
        step();
        checks++;
        if ({cmd_ready, done, Q_out} !== 6'b10_0111) begin
            errors++; $display("FAIL ign_end: ready/done/q=%b want 100111", {cmd_ready, done, Q_out});
        end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        ser_in_l = 1'b0;
        issue(OP_SHL, 2'b11, 1'b0, 4'b0000, 1'b0);
        step();
        step();
        checks++;
        if (Q_out !== 4'b1100) begin errors++; $display("FAIL mid_pre: got %b want 1100", Q_out); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (Q_out !== 4'b0000) begin errors++; $display("FAIL mid_reset_q: got %b want 0000", Q_out); end
        checks++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            errors++; $display("FAIL mid_reset_flags: ready/busy/done=%b want 100", {cmd_ready, busy, done});
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin errors++; $display("FAIL mid_no_done: saw %0d done cycles want 0", done_seen); end
        checks++;
        if ({cmd_ready, Q_out} !== 5'b1_0000) begin errors++; $display("FAIL mid_after: ready/q=%b want 10000", {cmd_ready, Q_out}); end
    endtask

    task automatic test_hold_back_to_back();
        issue(OP_LOAD, 2'b00, 1'b0, 4'b0110, 1'b0);
        step();
        step();
        issue(OP_HOLD, 2'b00, 1'b0, 4'b1111, 1'b0);
        checks++;
        if ({busy, done} !== 2'b10) begin errors++; $display("FAIL hold_exec: busy/done=%b want 10", {busy, done}); end
        step();
        checks++;
        if ({done, Q_out} !== 5'b1_0110) begin errors++; $display("FAIL hold_done: done/q=%b want 10110", {done, Q_out}); end
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_cnt = 2'b00; cmd_rot = 1'b0; load_data = 4'b1001;
        step();
        checks++;
        if ({done, cmd_ready, Q_out} !== 6'b01_0110) begin
            errors++; $display("FAIL hold_idle: done/ready/q=%b want 010110", {done, cmd_ready, Q_out});
        end
        step();
        cmd_valid = 1'b0;
        load_data = 4'b0000;
        checks++;
        if ({busy, cmd_ready} !== 2'b10) begin errors++; $display("FAIL b2b_accept: busy/ready=%b want 10", {busy, cmd_ready}); end
        step();
        checks++;
        if ({done, Q_out} !== 5'b1_1001) begin errors++; $display("FAIL b2b_done: done/q=%b want 11001", {done, Q_out}); end
        step();
    endtask

    // Sequence and report
    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_HOLD; cmd_cnt = 2'b00; cmd_rot = 1'b0;
        load_data = 4'b0000; ser_in_r = 1'b0; ser_in_l = 1'b0;
        #2;
        test_reset();
        test_first_accept();
        test_load();
        test_shr();
        test_serial_change();
        test_rotate();
        test_ignore();
        test_reset_mid();
        test_hold_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
